// File: rtl/inst_loader_enc_pkg.sv
// Shared types and constants for the RV32I instruction loader/encoder.
package inst_loader_enc_pkg;

  localparam int FMT_W  = 3;
  localparam int OPC_W  = 7;
  localparam int REG_W  = 5;
  localparam int F3_W   = 3;
  localparam int F7_W   = 7;
  localparam int IMM_W  = 32;
  localparam int INST_W = 32;

  typedef enum logic [FMT_W-1:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'h03;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'h13;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'h17;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'h23;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'h33;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'h37;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'h63;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'h67;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'h6F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/inst_enc.sv
// Combinational RV32I packer: field bundle + format -> 32-bit instruction word.
module inst_enc
  import inst_loader_enc_pkg::*;
(
  input  logic [FMT_W-1:0]  fmt_i,
  input  logic [OPC_W-1:0]  opcode_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic [F3_W-1:0]   funct3_i,
  input  logic [REG_W-1:0]  rs1_i,
  input  logic [REG_W-1:0]  rs2_i,
  input  logic [F7_W-1:0]   funct7_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic [INST_W-1:0] word_o,
  output logic              illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (fmt_e'(fmt_i))
      FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_loader_enc.sv
// Program loader: encodes field bundles and streams the words into instruction
// memory at consecutive addresses through a one-entry output register.
module inst_loader_enc
  import inst_loader_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FMT_W-1:0]  in_fmt,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [F3_W-1:0]   in_funct3,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [F7_W-1:0]   in_funct7,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INST_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INST_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic                last_q, last_d;
  logic [ADDR_W:0]     count_q, count_d;

  logic [INST_W-1:0]   enc_word;
  logic                enc_illegal;
  logic [ADDR_W:0]     count_pend;
  logic                wr_hs, drain_ok, end_cond, accept;

  inst_enc u_enc (
    .fmt_i     (in_fmt),
    .opcode_i  (in_opcode),
    .rd_i      (in_rd),
    .funct3_i  (in_funct3),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .funct7_i  (in_funct7),
    .imm_i     (in_imm),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  // Words written plus the one sitting in the output register.
  assign count_pend = count_q + {{ADDR_W{1'b0}}, we_q};
  assign wr_hs      = we_q & mem_ready;
  assign drain_ok   = ~we_q | mem_ready;
  assign end_cond   = last_q | (count_pend == DEPTH_C);
  assign in_ready   = (state_q == ST_LOAD) & ~end_cond & drain_ok;
  assign accept     = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = base_addr;
          count_d = '0;
          err_d   = 1'b0;
          last_d  = 1'b0;
          we_d    = 1'b0;
        end
      end
      ST_LOAD: begin
        if (wr_hs) begin
          we_d    = 1'b0;
          count_d = count_q + (ADDR_W+1)'(1);
          addr_d  = addr_q + ADDR_W'(1);
        end
        if (accept) begin
          last_d = in_last;
          if (enc_illegal) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            wdata_d = enc_word;
          end
        end
        // Nothing can be accepted once end_cond holds, so draining ends the session.
        if (end_cond && drain_ok) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == ST_LOAD);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_inst_loader_enc.sv
// Scoreboard bench for inst_loader_enc: directed RV32I vectors plus randomized
// sessions against an arithmetic reference encoder.
module tb_inst_loader_enc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b1;
  logic        busy, done, err;
  logic [8:0]  count;

  inst_loader_enc #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        last;
  } bnd_t;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t  sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   bp_hold = 0;
  bit   rnd_ready = 1'b0;
  logic [7:0] exp_addr = '0;
  int   exp_count = 0;
  bit   exp_err = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Reference encoder built from bit positions with shifts and masks.
  function automatic logic [31:0] model_enc(input bnd_t b);
    logic [31:0] w, imm, rd, f3, rs1, rs2, f7;
    imm = b.imm; rd = 32'(b.rd); f3 = 32'(b.f3);
    rs1 = 32'(b.rs1); rs2 = 32'(b.rs2); f7 = 32'(b.f7);
    w = 32'(b.op);
    case (b.fmt)
      3'd0: w = w | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
      3'd1: w = w | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
      3'd2: w = w | ((imm & 32'h1F) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                  | (((imm >> 5) & 32'h7F) << 25);
      3'd3: w = w | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                  | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                  | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
      3'd4: w = w | (rd << 7) | (imm & 32'hFFFFF000);
      3'd5: w = w | (rd << 7) | (((imm >> 12) & 32'hFF) << 12) | (((imm >> 11) & 32'h1) << 20)
                  | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 20) & 32'h1) << 31);
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic bnd_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [6:0] f7, input logic [31:0] imm, input logic last);
    bnd_t b;
    b.fmt = fmt; b.op = op; b.rd = rd; b.f3 = f3; b.rs1 = rs1;
    b.rs2 = rs2; b.f7 = f7; b.imm = imm; b.last = last;
    return b;
  endfunction

  function automatic bnd_t rnd_bnd(input bit allow_illegal, input logic last);
    bnd_t b;
    b.fmt  = allow_illegal ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
    b.op   = 7'($urandom);
    b.rd   = 5'($urandom);
    b.f3   = 3'($urandom);
    b.rs1  = 5'($urandom);
    b.rs2  = 5'($urandom);
    b.f7   = 7'($urandom);
    b.imm  = $urandom;
    b.last = last;
    return b;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the bundle was taken.
  task automatic send(input bnd_t b, input logic [31:0] exp_word, input bit use_exp, output int waits);
    bit  got;
    wr_t e;
    got = 1'b0;
    waits = 0;
    in_valid = 1'b1; in_fmt = b.fmt; in_opcode = b.op; in_rd = b.rd; in_funct3 = b.f3;
    in_rs1 = b.rs1; in_rs2 = b.rs2; in_funct7 = b.f7; in_imm = b.imm; in_last = b.last;
    while (!got && waits < 500) begin
      @(negedge clk);
      waits++;
      if (in_ready) begin
        got = 1'b1;
        if (b.fmt <= 3'd5) begin
          e.a = exp_addr;
          e.d = use_exp ? exp_word : model_enc(b);
          sb.push_back(e);
          exp_addr++;
          exp_count++;
        end else begin
          exp_err = 1'b1;
        end
      end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, expected a handshake", waits);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] b, input bit with_valid);
    start = 1'b1;
    base_addr = b;
    if (with_valid) in_valid = 1'b1;
    @(negedge clk);
    if (with_valid) chk("start_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    exp_addr = b; exp_count = 0; exp_err = 1'b0;
    @(negedge clk);
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_done", 64'(done), 64'd0);
    chk("start_addr", 64'(mem_addr), 64'(b));
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 2000);
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_count"}, 64'(count), 64'(exp_count));
    chk({nm, "_err"}, 64'(err), 64'(exp_err));
    chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (bp_hold > 0) begin
      mem_ready = 1'b0;
      bp_hold--;
    end else if (rnd_ready) begin
      mem_ready = ($urandom_range(0, 2) != 0);
    end else begin
      mem_ready = 1'b1;
    end
  end

  // Monitor: pops expected writes on each memory handshake, checks hold under stall.
  initial begin
    bit          prev_stall;
    logic [7:0]  prev_addr;
    logic [31:0] prev_data;
    wr_t         e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_we", 64'(mem_we), 64'd1);
          chk("hold_addr", 64'(mem_addr), 64'(prev_addr));
          chk("hold_data", 64'(mem_wdata), 64'(prev_data));
        end
        if (mem_we && !mem_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (mem_we && mem_ready) begin
          if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, mem_wdata);
          end else begin
            e = sb.pop_front();
            chk("wr_addr", 64'(mem_addr), 64'(e.a));
            chk("wr_data", 64'(mem_wdata), 64'(e.d));
          end
        end
        prev_stall = mem_we && !mem_ready;
        prev_addr = mem_addr;
        prev_data = mem_wdata;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int   w;
    bnd_t b;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed encodings, base 0x10, with a 3-cycle memory stall in the middle.
    do_start(8'h10, 1'b1);
    send(mk(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'($urandom), 7'($urandom), 32'd5, 1'b0), 32'h00500093, 1'b1, w);
    bp_hold = 3;
    send(mk(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, $urandom, 1'b0), 32'h002081B3, 1'b1, w);
    send(mk(3'd2, 7'h23, 5'($urandom), 3'd2, 5'd1, 5'd2, 7'($urandom), 32'd8, 1'b0), 32'h0020A423, 1'b1, w);
    send(mk(3'd3, 7'h63, 5'($urandom), 3'd0, 5'd0, 5'd0, 7'($urandom), 32'hFFFFFFFC, 1'b0), 32'hFE000EE3, 1'b1, w);
    send(mk(3'd5, 7'h6F, 5'd1, 3'($urandom), 5'($urandom), 5'($urandom), 7'($urandom), 32'd8, 1'b0), 32'h008000EF, 1'b1, w);
    send(mk(3'd4, 7'h37, 5'd5, 3'($urandom), 5'($urandom), 5'($urandom), 7'($urandom), 32'h12345000, 1'b1), 32'h123452B7, 1'b1, w);
    wait_done("directed");

    // Address wrap at 0xFF with full throughput.
    rnd_ready = 1'b0;
    do_start(8'hFE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(rnd_bnd(1'b0, logic'(i == 3)), 32'h0, 1'b0, w);
      chk("throughput_wait", 64'(w), 64'd1);
    end
    wait_done("wrap");

    // Illegal format carrying in_last: no write, err set, session ends.
    do_start(8'h33, 1'b0);
    send(mk(3'd6, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 1'b1), 32'h0, 1'b0, w);
    wait_done("illegal_last");

    // Random session with random backpressure, illegal formats and a start pulse in LOAD.
    rnd_ready = 1'b1;
    do_start(8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      b = rnd_bnd(1'b1, logic'(i == 39));
      if (i == 10) begin
        start = 1'b1;
        base_addr = ~exp_addr;
      end
      send(b, 32'h0, 1'b0, w);
      start = 1'b0;
    end
    wait_done("random");

    // Depth limit reached without in_last.
    rnd_ready = 1'b0;
    do_start(8'($urandom), 1'b0);
    for (int i = 0; i < 256; i++) send(rnd_bnd(1'b0, 1'b0), 32'h0, 1'b0, w);
    wait_done("depth");
    chk("depth_in_ready", 64'(in_ready), 64'd0);

    // Asynchronous reset while a write is stalled, then a fresh session.
    do_start(8'h40, 1'b0);
    bp_hold = 1000;
    send(rnd_bnd(1'b0, 1'b0), 32'h0, 1'b0, w);
    @(negedge clk);
    chk("pre_rst_we", 64'(mem_we), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 64'(mem_we), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_wdata", 64'(mem_wdata), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    bp_hold = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(8'h80, 1'b0);
    send(rnd_bnd(1'b0, 1'b0), 32'h0, 1'b0, w);
    send(rnd_bnd(1'b0, 1'b1), 32'h0, 1'b0, w);
    wait_done("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
